mem_port_arbiter: RTL

//  Shares one unified memory port between instruction fetch (IF) and the data memory controller (DM).

---
 rtl/mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory port between the instruction-fetch side (IF) and
// the data-memory controller (DM). A winning request is latched into the port
// registers, the port is driven until the memory acknowledges, and the result
// is returned as registered read data with a one-cycle Ready pulse.
//
// Arbitration gives DM priority, but after STARVE_LIMIT consecutive DM grants
// while IF is waiting, the next grant goes to IF. An access that gets no ack
// within TIMEOUT cycles is aborted and completed with a Bus_Err pulse.
//
// Parameters
//   STARVE_LIMIT : consecutive DM grants allowed while IF is waiting
//   TIMEOUT      : cycles without ack before abort (0 disables the timeout)
//
// Ports
//   i_clk              clock, all state updates on the rising edge
//   i_rst_n            synchronous active-low reset
//   i_if_read          fetch request, held until o_if_ready
//   i_if_addr          fetch address
//   o_if_ready         1-cycle pulse, fetch complete, o_if_data valid
//   o_if_data          fetched word (registered, held between fetches)
//   i_dm_read          data read request, held until o_dm_ready
//   i_dm_write         data write request, held until o_dm_ready
//   i_dm_addr          data address
//   i_dm_write_data    store data
//   i_dm_byte_enable   store byte lanes
//   o_dm_ready         1-cycle pulse, data access complete
//   o_dm_read_data     load data (registered, held between loads)
//   o_bus_err          1-cycle pulse together with Ready when the access timed out
//   o_mem_addr         port address
//   o_mem_write_data   port store data
//   o_mem_byte_enable  port byte lanes (all ones for reads)
//   o_mem_read_enable  port read strobe, level, held until ack
//   o_mem_write_enable port write strobe, level, held until ack
//   i_mem_read_data    port read data, valid with i_mem_ack
//   i_mem_ack          port completion, 1 cycle
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_read,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ready,
    output logic [31:0] o_if_data,
    input  logic        i_dm_read,
    input  logic        i_dm_write,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_write_data,
    input  logic [3:0]  i_dm_byte_enable,
    output logic        o_dm_ready,
    output logic [31:0] o_dm_read_data,
    output logic        o_bus_err,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_write_data,
    output logic [3:0]  o_mem_byte_enable,
    output logic        o_mem_read_enable,
    output logic        o_mem_write_enable,
    input  logic [31:0] i_mem_read_data,
    input  logic        i_mem_ack
);

    // Parameter values narrowed once to the widths of the counters they
    // are compared against.
    localparam logic [7:0] L_STARVE_LIMIT = 8'(STARVE_LIMIT);
    localparam bit         L_TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [7:0] L_TIMEOUT_LAST = 8'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Arbitration / completion decisions for the current cycle
    logic        w_dm_req;
    logic        w_dm_wins;
    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_ack_done;
    logic        w_timeout;
    logic        w_busy;

    // Control state
    logic [7:0]  r_timer;
    logic [7:0]  r_starve;

    // Port registers
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_write_data;
    logic [3:0]  r_mem_byte_enable;
    logic        r_mem_re;
    logic        r_mem_we;

    // Requester-side result registers
    logic        r_if_ready;
    logic        r_dm_ready;
    logic        r_bus_err;
    logic [31:0] r_if_data;
    logic [31:0] r_dm_read_data;

    // ------------------------------------------------------------------------
    // Next-state and decision logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        w_ack_done   = 1'b0;
        w_timeout    = 1'b0;
        w_busy       = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);
        w_dm_req     = i_dm_read | i_dm_write;
        // DM has priority unless IF is waiting and has already been passed
        // over STARVE_LIMIT times in a row.
        w_dm_wins    = w_dm_req & (~i_if_read | (r_starve < L_STARVE_LIMIT));

        case (r_state)
            S_IDLE: begin
                if (w_dm_wins) begin
                    w_grant_d    = 1'b1;
                    w_next_state = S_BUSY_D;
                end else if (i_if_read) begin
                    w_grant_i    = 1'b1;
                    w_next_state = S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (i_mem_ack) begin
                    w_ack_done   = 1'b1;
                    w_next_state = S_DONE;
                end else if (L_TIMEOUT_EN && (r_timer == L_TIMEOUT_LAST)) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                // The completed requester has exactly this cycle to drop its
                // request; whatever is still asserted in IDLE counts as new.
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Port, timer, starvation and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_timer           <= 8'd0;
            r_starve          <= 8'd0;
            r_mem_addr        <= 32'd0;
            r_mem_write_data  <= 32'd0;
            r_mem_byte_enable <= 4'd0;
            r_mem_re          <= 1'b0;
            r_mem_we          <= 1'b0;
            r_if_ready        <= 1'b0;
            r_dm_ready        <= 1'b0;
            r_bus_err         <= 1'b0;
            r_if_data         <= 32'd0;
            r_dm_read_data    <= 32'd0;
        end else begin
            // Completion pulses last a single cycle
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            r_bus_err  <= 1'b0;

            // Grant: snapshot the winner so later requester changes cannot
            // disturb the access in flight. Read+write together is a write.
            if (w_grant_d) begin
                r_mem_addr        <= i_dm_addr;
                r_mem_write_data  <= i_dm_write_data;
                r_mem_byte_enable <= i_dm_write ? i_dm_byte_enable : 4'b1111;
                r_mem_we          <= i_dm_write;
                r_mem_re          <= ~i_dm_write;
                r_timer           <= 8'd0;
                r_starve          <= r_starve + {7'd0, i_if_read};
            end else if (w_grant_i) begin
                r_mem_addr        <= i_if_addr;
                r_mem_write_data  <= 32'd0;
                r_mem_byte_enable <= 4'b1111;
                r_mem_we          <= 1'b0;
                r_mem_re          <= 1'b1;
                r_timer           <= 8'd0;
                r_starve          <= 8'd0;
            end

            // Completion (ack or abort): drop the strobes, hand the result to
            // the owner. Only reads update the owner's data register; an
            // aborted read returns zero.
            if (w_ack_done || w_timeout) begin
                r_mem_re  <= 1'b0;
                r_mem_we  <= 1'b0;
                r_bus_err <= w_timeout;
                if (r_state == S_BUSY_I) begin
                    r_if_ready <= 1'b1;
                    if (r_mem_re) begin
                        r_if_data <= w_timeout ? 32'd0 : i_mem_read_data;
                    end
                end else begin
                    r_dm_ready <= 1'b1;
                    if (r_mem_re) begin
                        r_dm_read_data <= w_timeout ? 32'd0 : i_mem_read_data;
                    end
                end
            end else if (w_busy) begin
                r_timer <= r_timer + 8'd1;
            end

            if (r_state == S_DONE) begin
                r_timer <= 8'd0;
            end
        end
    end

    assign o_if_ready         = r_if_ready;
    assign o_if_data          = r_if_data;
    assign o_dm_ready         = r_dm_ready;
    assign o_dm_read_data     = r_dm_read_data;
    assign o_bus_err          = r_bus_err;
    assign o_mem_addr         = r_mem_addr;
    assign o_mem_write_data   = r_mem_write_data;
    assign o_mem_byte_enable  = r_mem_byte_enable;
    assign o_mem_read_enable  = r_mem_re;
    assign o_mem_write_enable = r_mem_we;

endmodule
